sci_acc_op_pkt_fifo: RTL and testbench
======================================

Name: sci_acc_op_pkt_fifo

Overview:
- Producer-side operation-packet queue feeding the Maclaurin compute core's op input interface.
- Accepts op packets from the host/command decoder: operand data, one-hot mode, resolution (number of series terms).
- Buffers up to DEPTH packets and presents the head packet first-word-fall-through. Retires the head when the core pulses fifo_pop.
- Rejects malformed packets (non-one-hot mode) and tracks overflow, underflow and bad-mode errors as sticky status.

Parameters:
- DATA_WIDTH, 32, operand width (IEEE-754 single).
- NUM_MODES, 4, number of one-hot function-mode bits.
- RES_WIDTH, 4, resolution / term-count field width.
- DEPTH, 8, packet entries; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- host_wr_en  in  1  push request.
- host_data  in  DATA_WIDTH  operand to enqueue.
- host_mode  in  NUM_MODES  one-hot mode to enqueue.
- host_res  in  RES_WIDTH  resolution to enqueue.
- host_wr_ready  out  1  queue can accept a push this cycle.
- in_fifo_data_o  out  DATA_WIDTH  head operand.
- in_fifo_mode_o  out  NUM_MODES  head mode.
- in_fifo_res_o  out  RES_WIDTH  head resolution.
- op_pkt_available  out  1  head entry valid.
- fifo_pop  in  1  core consumes head.
- err_clr  in  1  clears all sticky error flags.
- occupancy  out  CNT_W  stored packet count, 0..DEPTH.
- ovf_err  out  1  sticky: push attempted while full.
- unf_err  out  1  sticky: pop while empty.
- mode_err  out  1  sticky: push with non-one-hot mode.

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset_n is asynchronous, active-low. On assertion, clear immediately: wr_ptr, rd_ptr, occupancy, all error flags, op_pkt_available.
  - Reset values: host_wr_ready=1 (combinational from empty), op_pkt_available=0, in_fifo_*_o=0, occupancy=0, ovf_err=unf_err=mode_err=0.
  - Storage array is not reset. in_fifo_*_o is forced to 0 whenever the queue is empty.
- Storage: circular buffer of DEPTH entries {data, mode, res}. Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0. Full/empty is derived from occupancy, not from pointer comparison.
- Push accept condition: host_wr_en && host_wr_ready && mode_valid.
  - mode_valid means exactly one bit of host_mode is set.
  - An accepted push writes the entry at wr_ptr on the clock edge and increments wr_ptr.
- Combinational outputs:
  - host_wr_ready = (occupancy != DEPTH).
  - op_pkt_available = (occupancy != 0).
  - in_fifo_*_o = entry[rd_ptr].
- Push latency: a packet pushed at edge N into an empty queue shows op_pkt_available=1 and valid head fields in the cycle after edge N. There is no bypass of an empty queue in the same cycle.
- Pop accept condition: fifo_pop && op_pkt_available. Increments rd_ptr at the edge; the next head is visible the following cycle.
- Simultaneous accepted push and pop: occupancy is unchanged and both pointers advance.
- Push while full: dropped and ovf_err is set, even if a pop is accepted in the same cycle. host_wr_ready is low whenever full, so the producer must wait one cycle.
- Push with invalid mode (zero or multi-hot): dropped, mode_err set, occupancy unchanged. If the queue is also full, set both ovf_err and mode_err.
- fifo_pop while empty: ignored, unf_err set.
- Error flags:
  - Sticky until err_clr.
  - err_clr clears the flags at the edge.
  - If err_clr and a new error event occur in the same cycle, the new error wins and the flag stays 1.
- Head stability: the core holds fifo_pop as a single-cycle pulse per packet. Head fields must remain stable while op_pkt_available=1 and no pop is accepted, regardless of concurrent pushes.
- Occupancy: never exceeds DEPTH and never underflows below 0.

Test Plan:
- Reset, then push {data=0x3F800000, mode=4'b0001, res=4'd5} → next cycle op_pkt_available=1, in_fifo_data_o=0x3F800000, in_fifo_res_o=5, occupancy=1; pulse fifo_pop → next cycle op_pkt_available=0, outputs 0, occupancy=0.
- Push 8 packets with data 1..8 → host_wr_ready=0, occupancy=8; 9th push → dropped, ovf_err=1; pop 8 times → heads appear in order 1..8; then a pop on empty → unf_err=1.
- Fill to 8, then in one cycle push data=9 and pop → push dropped, ovf_err=1, occupancy=7; at half-full, simultaneous push+pop for 20 cycles → occupancy constant and pointers wrap with FIFO order preserved.
- Push with mode=4'b0000, then mode=4'b0110 → both dropped, mode_err=1, occupancy=0; err_clr pulse → mode_err=0; err_clr in the same cycle as a bad push → mode_err stays 1.
- With 3 entries queued, assert reset_n=0 mid-cycle → asynchronously op_pkt_available=0, occupancy=0, errors=0; after release, push one packet → it is the head (old entries are not visible).

Source files
------------

// File: rtl/sci_acc_op_pkt_fifo_if.sv
// Op-packet handshake bundle: host push side plus core-facing head/pop side.
interface sci_acc_op_pkt_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MODES  = 4,
  parameter int RES_WIDTH  = 4
);
  logic                  host_wr_en;
  logic [DATA_WIDTH-1:0] host_data;
  logic [NUM_MODES-1:0]  host_mode;
  logic [RES_WIDTH-1:0]  host_res;
  logic                  host_wr_ready;
  logic [DATA_WIDTH-1:0] in_fifo_data_o;
  logic [NUM_MODES-1:0]  in_fifo_mode_o;
  logic [RES_WIDTH-1:0]  in_fifo_res_o;
  logic                  op_pkt_available;
  logic                  fifo_pop;

  // Queue side: takes pushes and pops, presents the head.
  modport slave (
    input  host_wr_en, host_data, host_mode, host_res, fifo_pop,
    output host_wr_ready, in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o,
           op_pkt_available
  );

  // Producer/consumer side: drives pushes and pops, observes the head.
  modport master (
    output host_wr_en, host_data, host_mode, host_res, fifo_pop,
    input  host_wr_ready, in_fifo_data_o, in_fifo_mode_o, in_fifo_res_o,
           op_pkt_available
  );
endinterface

// File: rtl/sci_acc_op_pkt_fifo.sv
// Op-packet queue in front of the Maclaurin core. First-word-fall-through
// head, occupancy-based full/empty, sticky overflow/underflow/bad-mode flags.
module sci_acc_op_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MODES  = 4,
  parameter int RES_WIDTH  = 4,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sci_acc_op_pkt_fifo_if.slave bus,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 ovf_err,
  output logic                 unf_err,
  output logic                 mode_err
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NUM_MODES-1:0]  mode;
    logic [RES_WIDTH-1:0]  res;
  } pkt_t;

  pkt_t             mem [DEPTH];
  pkt_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, mode_valid, push_ok, pop_ok;
  logic             ovf_set, unf_set, mode_set;

  assign full       = (occupancy == CNT_W'(DEPTH));
  assign empty      = (occupancy == '0);
  assign mode_valid = $onehot(bus.host_mode);
  // Full blocks pushes even when a pop lands in the same cycle.
  assign push_ok    = bus.host_wr_en && !full && mode_valid;
  assign pop_ok     = bus.fifo_pop && !empty;
  assign ovf_set    = bus.host_wr_en && full;
  assign mode_set   = bus.host_wr_en && !mode_valid;
  assign unf_set    = bus.fifo_pop && empty;

  assign bus.host_wr_ready    = !full;
  assign bus.op_pkt_available = !empty;
  // Stale storage is never visible: the head reads as zero when empty.
  assign head                 = empty ? '0 : mem[rd_ptr];
  assign bus.in_fifo_data_o   = head.data;
  assign bus.in_fifo_mode_o   = head.mode;
  assign bus.in_fifo_res_o    = head.res;

  // Storage write; no reset on the array.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{data: bus.host_data, mode: bus.host_mode, res: bus.host_res};
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Sticky error flags; a new event beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
      mode_err <= 1'b0;
    end else begin
      ovf_err  <= ovf_set  | (ovf_err  & ~err_clr);
      unf_err  <= unf_set  | (unf_err  & ~err_clr);
      mode_err <= mode_set | (mode_err & ~err_clr);
    end
  end
endmodule

// File: tb/tb_sci_acc_op_pkt_fifo.sv
// Directed bench for sci_acc_op_pkt_fifo: queue-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_sci_acc_op_pkt_fifo;
  localparam int DW = 32, NM = 4, RW = 4, DEPTH = 8, CNT_W = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [NM-1:0] mode;
    logic [RW-1:0] res;
  } pkt_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic err_clr = 1'b0;
  logic [CNT_W-1:0] occupancy;
  logic ovf_err, unf_err, mode_err;
  int n_chk = 0, n_fail = 0;
  bit started = 0;

  sci_acc_op_pkt_fifo_if #(.DATA_WIDTH(DW), .NUM_MODES(NM), .RES_WIDTH(RW)) bus ();

  sci_acc_op_pkt_fifo #(.DATA_WIDTH(DW), .NUM_MODES(NM), .RES_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .err_clr(err_clr),
    .occupancy(occupancy), .ovf_err(ovf_err), .unf_err(unf_err), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain packet queue and three sticky bits.
  pkt_t q[$];
  bit m_ovf, m_unf, m_mode;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_mode = 0;
    end else begin
      bit was_full, was_empty, good_mode;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      good_mode = ($countones(bus.host_mode) == 1);
      if (err_clr) begin m_ovf = 0; m_unf = 0; m_mode = 0; end
      if (bus.host_wr_en && was_full)   m_ovf = 1;
      if (bus.host_wr_en && !good_mode) m_mode = 1;
      if (bus.fifo_pop && was_empty)    m_unf = 1;
      if (bus.fifo_pop && !was_empty) void'(q.pop_front());
      if (bus.host_wr_en && !was_full && good_mode)
        q.push_back('{data: bus.host_data, mode: bus.host_mode, res: bus.host_res});
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (started && reset_n) begin
      pkt_t h;
      h = (q.size() != 0) ? q[0] : '{data: '0, mode: '0, res: '0};
      chk("m_ready", 64'(bus.host_wr_ready), 64'(q.size() != DEPTH));
      chk("m_avail", 64'(bus.op_pkt_available), 64'(q.size() != 0));
      chk("m_data", 64'(bus.in_fifo_data_o), 64'(h.data));
      chk("m_mode", 64'(bus.in_fifo_mode_o), 64'(h.mode));
      chk("m_res", 64'(bus.in_fifo_res_o), 64'(h.res));
      chk("m_occ", 64'(occupancy), 64'(q.size()));
      chk("m_errs", 64'({ovf_err, unf_err, mode_err}), 64'({m_ovf, m_unf, m_mode}));
    end
  end

  // One clock of stimulus; returns 1ns after the edge with inputs idle.
  task automatic cyc(input logic we, input logic [DW-1:0] d, input logic [NM-1:0] m,
                     input logic [RW-1:0] r, input logic pop, input logic clr);
    bus.host_wr_en = we; bus.host_data = d; bus.host_mode = m; bus.host_res = r;
    bus.fifo_pop = pop; err_clr = clr;
    @(posedge clk); #1;
    bus.host_wr_en = 0; bus.host_data = '0; bus.host_mode = '0; bus.host_res = '0;
    bus.fifo_pop = 0; err_clr = 0;
  endtask

  initial begin
    bus.host_wr_en = 0; bus.host_data = '0; bus.host_mode = '0; bus.host_res = '0;
    bus.fifo_pop = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.host_wr_ready), 64'd1);
    chk("rst_avail", 64'(bus.op_pkt_available), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_data", 64'(bus.in_fifo_data_o), 64'd0);
    chk("rst_errs", 64'({ovf_err, unf_err, mode_err}), 64'd0);
    reset_n = 1;
    started = 1;
    @(posedge clk); #1;

    // Single packet in and out.
    cyc(1, 32'h3F800000, 4'b0001, 4'd5, 0, 0);
    chk("s1_avail", 64'(bus.op_pkt_available), 64'd1);
    chk("s1_data", 64'(bus.in_fifo_data_o), 64'h3F800000);
    chk("s1_res", 64'(bus.in_fifo_res_o), 64'd5);
    chk("s1_occ", 64'(occupancy), 64'd1);
    cyc(0, '0, '0, '0, 1, 0);
    chk("s1_avail0", 64'(bus.op_pkt_available), 64'd0);
    chk("s1_data0", 64'(bus.in_fifo_data_o), 64'd0);
    chk("s1_occ0", 64'(occupancy), 64'd0);

    // Fill, overflow, drain in order, underflow.
    for (int i = 1; i <= 8; i++) cyc(1, DW'(i), 4'b0010, RW'(i), 0, 0);
    chk("fill_ready", 64'(bus.host_wr_ready), 64'd0);
    chk("fill_occ", 64'(occupancy), 64'd8);
    cyc(1, 32'd9, 4'b0010, 4'd9, 0, 0);
    chk("ovf_flag", 64'(ovf_err), 64'd1);
    chk("ovf_occ", 64'(occupancy), 64'd8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_head", 64'(bus.in_fifo_data_o), 64'(i));
      cyc(0, '0, '0, '0, 1, 0);
    end
    cyc(0, '0, '0, '0, 1, 0);
    chk("unf_flag", 64'(unf_err), 64'd1);
    chk("unf_occ", 64'(occupancy), 64'd0);

    // Full with simultaneous push+pop, then steady-state push+pop with wrap.
    cyc(0, '0, '0, '0, 0, 1);
    chk("clr_errs", 64'({ovf_err, unf_err, mode_err}), 64'd0);
    for (int i = 1; i <= 8; i++) cyc(1, 32'h100 + DW'(i), 4'b0100, 4'd3, 0, 0);
    cyc(1, 32'd9, 4'b0100, 4'd3, 1, 0);
    chk("fp_ovf", 64'(ovf_err), 64'd1);
    chk("fp_occ", 64'(occupancy), 64'd7);
    chk("fp_head", 64'(bus.in_fifo_data_o), 64'h102);
    repeat (3) cyc(0, '0, '0, '0, 1, 0);
    chk("half_occ", 64'(occupancy), 64'd4);
    for (int k = 0; k < 20; k++) cyc(1, 32'h200 + DW'(k), 4'b1000, RW'(k), 1, 0);
    chk("pp_occ", 64'(occupancy), 64'd4);
    chk("pp_head", 64'(bus.in_fifo_data_o), 64'h210);
    chk("pp_mode", 64'(bus.in_fifo_mode_o), 64'b1000);
    repeat (4) cyc(0, '0, '0, '0, 1, 0);

    // Bad modes and clear priority.
    cyc(0, '0, '0, '0, 0, 1);
    cyc(1, 32'hA, 4'b0000, 4'd1, 0, 0);
    cyc(1, 32'hB, 4'b0110, 4'd1, 0, 0);
    chk("bad_mode", 64'(mode_err), 64'd1);
    chk("bad_occ", 64'(occupancy), 64'd0);
    cyc(0, '0, '0, '0, 0, 1);
    chk("clr_mode", 64'(mode_err), 64'd0);
    cyc(1, 32'hC, 4'b1100, 4'd1, 0, 1);
    chk("clr_vs_new", 64'(mode_err), 64'd1);

    // Asynchronous reset mid-cycle with entries queued.
    for (int i = 0; i < 3; i++) cyc(1, 32'h50 + DW'(i), 4'b0001, 4'd2, 0, 0);
    #2 reset_n = 0;
    #1;
    chk("arst_avail", 64'(bus.op_pkt_available), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_errs", 64'({ovf_err, unf_err, mode_err}), 64'd0);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    cyc(1, 32'hABC, 4'b0010, 4'd7, 0, 0);
    chk("post_head", 64'(bus.in_fifo_data_o), 64'hABC);
    chk("post_occ", 64'(occupancy), 64'd1);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
